seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed N-digit seven-segment display driver.
//  - Successor to the single-digit combinational BCD-to-LED decoder.
//  - Scans NUM_DIGITS common-anode digits from a packed 4-bit-per-digit value.
//  - Adds: hex/BCD glyph mode, per-digit decimal points, leading-zero blanking,

---
 rtl/seven_seg_scan_driver_pkg.sv | 25 ++
 rtl/seven_seg_scan_driver_if.sv | 24 ++
 rtl/seven_seg_scan_driver_decode.sv | 33 +++
 rtl/seven_seg_scan_driver.sv | 101 ++++++++++
 tb/tb_seven_seg_scan_driver.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared glyph constants for the seven-segment scan driver.
// All glyphs are active-low with bit 0 = segment a through bit 6 = segment g.
package seven_seg_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Datapath-facing bundle of the scan driver: display controls in, pin drives out.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      hex_mode;
  logic                      lz_blank;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_tick;

  modport master (
    output enable, hex_mode, lz_blank, value, dp_in,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  enable, hex_mode, lz_blank, value, dp_in,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_driver_decode.sv
// Combinational 4-bit code to active-low glyph decoder.
// In BCD mode, codes above 9 decode to blank.
module seven_seg_scan_driver_decode
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output seg_t       glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    unique case (code)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: glyph = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: glyph = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: glyph = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: glyph = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: glyph = hex_mode ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display scanner with frame snapshots,
// leading-zero blanking and an all-anodes-off guard at the start of each slot.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_seg_scan_driver_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    tc, frame_end, slot_on, visible, nz_run;
  logic [NUM_DIGITS-1:0]   nz_from;
  logic [3:0]              cur_code;
  seg_t                    cur_glyph;

  seven_seg_scan_driver_decode u_decode (
    .code     (cur_code),
    .hex_mode (bus.hex_mode),
    .glyph    (cur_glyph)
  );

  always_comb begin
    tc        = (cnt_q == CNT_LAST);
    frame_end = tc && (idx_q == IDX_LAST);
    cnt_d     = tc ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    if (frame_end) begin
      snap_val_d = bus.value;
      snap_dp_d  = bus.dp_in;
    end

    // nz_from[i]: some snapshot digit at position i or further left is nonzero
    nz_run  = 1'b0;
    nz_from = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      nz_run = nz_run | (|snap_val_q[4*(NUM_DIGITS-1-k) +: 4]);
      nz_from[NUM_DIGITS-1-k] = nz_run;
    end

    cur_code = snap_val_q[4*idx_q +: 4];
    visible  = (idx_q == '0) || !bus.lz_blank || nz_from[idx_q];
    slot_on  = bus.enable && (cnt_q >= BLANK_END);

    an_d = '1;
    if (slot_on) an_d[idx_q] = 1'b0;
    seg_d        = (slot_on && visible) ? cur_glyph : SEG_BLANK;
    dp_d         = !(slot_on && snap_dp_q[idx_q]);
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for the scan driver: cycle-count based reference model compared every
// cycle, plus literal glyph/anode expectations for directed scenarios.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyphs described by which segments are lit, turned into active-low codes.
  string lit_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    logic [6:0] lit;
    string s;
    lit = '0;
    if (code > 9 && !hex) return 7'h7F;
    s = lit_segs[code];
    for (int k = 0; k < s.len(); k++) lit[s[k] - 8'h61] = 1'b1;
    return ~lit;
  endfunction

  // Reference model: scan position derived purely from cycles since reset.
  int unsigned m;
  logic [15:0] sv;
  logic [3:0]  sd;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_ft;
  int          mc, mi;
  bit          mon, mvis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = 0; sv = '0; sd = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_ft = 1'b0;
    end else begin
      mc   = int'(m % RD);
      mi   = int'((m / RD) % N);
      mon  = bus.enable && (mc >= BC);
      mvis = (mi == 0) || !bus.lz_blank || ((sv >> (4*mi)) != 0);
      exp_an  = mon ? ~(4'b0001 << mi) : 4'hF;
      exp_seg = (mon && mvis) ? glyph(4'((sv >> (4*mi)) & 16'hF), bus.hex_mode) : 7'h7F;
      exp_dp  = !(mon && sd[mi]);
      exp_ft  = (m % (RD*N)) == (RD*N - 1);
      if (exp_ft) begin
        sv = bus.value;
        sd = bus.dp_in;
      end
      m++;
    end
  end

  int cyc = 0;
  int last_tick = -1;
  int lows;

  always @(posedge clk) begin
    #1;
    cyc++;
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("dp", 32'(bus.dp), 32'(exp_dp));
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
    lows = 0;
    for (int k = 0; k < N; k++) if (!bus.an[k]) lows++;
    chk("an_onehot", 32'(lows <= 1), 32'd1);
    if (reset) last_tick = -1;
    else if (bus.frame_tick) begin
      if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'd32);
      last_tick = cyc;
    end
  end

  task automatic wait_tick(input string name);
    bit found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (bus.frame_tick) found = 1;
    end
    if (!found) chk({name, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_slot(input string name, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (bus.an == an_e) found = 1;
    end
    if (!found) chk({name, "_an_timeout"}, 32'(bus.an), 32'(an_e));
    else begin
      chk({name, "_seg"}, 32'(bus.seg), 32'(seg_e));
      chk({name, "_dp"}, 32'(bus.dp), 32'(dp_e));
    end
  endtask

  initial begin
    bus.enable = 1'b1; bus.hex_mode = 1'b0; bus.lz_blank = 1'b0;
    bus.value = 16'h1234; bus.dp_in = 4'h0;

    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_ft", 32'(bus.frame_tick), 32'h0);
    reset = 1'b0;

    // 2. scan order and glyphs
    wait_tick("s2");
    expect_slot("s2_d0", 4'hE, 7'h19, 1'b1);
    expect_slot("s2_d1", 4'hD, 7'h30, 1'b1);
    expect_slot("s2_d2", 4'hB, 7'h24, 1'b1);
    expect_slot("s2_d3", 4'h7, 7'h79, 1'b1);

    // async reset mid-slot
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_an", 32'(bus.an), 32'hF);
    chk("arst_dp", 32'(bus.dp), 32'h1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // 3. hex mode and leading-zero blanking
    bus.value = 16'h00A0; bus.lz_blank = 1'b1; bus.hex_mode = 1'b1;
    wait_tick("s3a");
    wait_tick("s3b");
    expect_slot("s3_d0", 4'hE, 7'h40, 1'b1);
    expect_slot("s3_d1", 4'hD, 7'h08, 1'b1);
    expect_slot("s3_d2", 4'hB, 7'h7F, 1'b1);
    expect_slot("s3_d3", 4'h7, 7'h7F, 1'b1);
    @(negedge clk); bus.hex_mode = 1'b0;
    expect_slot("s3_bcd_d1", 4'hD, 7'h7F, 1'b1);

    // 4. tear-free snapshot
    @(negedge clk);
    bus.lz_blank = 1'b0; bus.hex_mode = 1'b1; bus.value = 16'h1111;
    wait_tick("s4a");
    wait_tick("s4b");
    repeat (10) @(negedge clk);
    bus.value = 16'h2222;
    expect_slot("s4_old_d2", 4'hB, 7'h79, 1'b1);
    expect_slot("s4_old_d3", 4'h7, 7'h79, 1'b1);
    wait_tick("s4c");
    expect_slot("s4_new_d0", 4'hE, 7'h24, 1'b1);

    // 5. decimal point and enable
    @(negedge clk);
    bus.value = 16'h0000; bus.dp_in = 4'b0100;
    wait_tick("s5a");
    wait_tick("s5b");
    expect_slot("s5_d0", 4'hE, 7'h40, 1'b1);
    expect_slot("s5_d2", 4'hB, 7'h40, 1'b0);
    @(negedge clk); bus.enable = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("s5_off_an", 32'(bus.an), 32'hF);
    end
    bus.enable = 1'b1;

    // 6. random streams
    for (int k = 0; k < 900; k++) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) bus.value = 16'($urandom);
      if ($urandom_range(5) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(19) == 0) bus.hex_mode = ~bus.hex_mode;
      if ($urandom_range(19) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(29) == 0) bus.enable = ~bus.enable;
      if (k == 450) begin
        #($urandom_range(4) + 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
